// File: rtl/window_scheduler.sv
// Window search sequencer: header/template load, window stepping, memory port arbitration.
// Optional watchdog on window_handler enabled by defining SCHED_TIMEOUT_EN.
module window_scheduler #(
   parameter int SET_WORDS      = 1665,
   parameter int TEMPLATE_WORDS = 64,
   parameter int IMG_DIM        = 80,
   parameter int WIN_DIM        = 16,
   parameter int STEP           = 4,
   parameter int NUM_SETS       = 4
`ifdef SCHED_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        set_done,
   output logic        all_done,
   output logic [15:0] set_index,
   output logic [7:0]  header,
   output logic [20:0] mem_addr,
   input  logic [31:0] mem_rd_data,
   output logic        tmpl_we,
   output logic [5:0]  tmpl_addr,
   output logic [31:0] tmpl_data,
   output logic        wh_en,
   output logic [6:0]  wh_row,
   output logic [6:0]  wh_col,
   input  logic [20:0] wh_addr,
   input  logic        wh_done,
   output logic        win_valid,
   output logic [8:0]  win_index,
   input  logic        win_ack,
   output logic        error
);

   localparam logic [6:0]  LAST_POS  = 7'(IMG_DIM - WIN_DIM);
   localparam logic [6:0]  STEP_W    = 7'(STEP);
   localparam logic [6:0]  TW        = 7'(TEMPLATE_WORDS);
   localparam logic [15:0] NSETS     = 16'(NUM_SETS);
   localparam logic [20:0] SET_W     = 21'(SET_WORDS);
   localparam logic [20:0] IMG_OFS   = 21'(1 + TEMPLATE_WORDS);

   typedef enum logic [2:0] {
      IDLE, HDR, TMPL, WIN_START, WIN_WAIT, WIN_HOLD, NEXT_SET, DONE
   } state_t;

   state_t      state, state_nxt;
   logic [20:0] set_base;
   logic [6:0]  k;
   logic        advance;
   logic        last_pos;
   logic [20:0] img_base;

   assign last_pos = (wh_row == LAST_POS) && (wh_col == LAST_POS);
   assign img_base = set_base + IMG_OFS;

`ifdef SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] wd_cnt;
   logic            timeout;
   assign timeout = (state == WIN_WAIT) && !wh_done && (wd_cnt == WD_LAST);
`else
   assign error = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      mem_addr  = '0;
      tmpl_we   = 1'b0;
      tmpl_addr = '0;
      tmpl_data = '0;
      wh_en     = 1'b0;
      win_valid = 1'b0;
      set_done  = 1'b0;
      all_done  = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = HDR;
         end
         HDR: begin
            mem_addr  = set_base;
            state_nxt = TMPL;
         end
         // address k goes out at step k, its data is written at step k+1
         TMPL: begin
            if (k < TW) mem_addr = set_base + 21'd1 + 21'(k);
            if (k != 7'd0) begin
               tmpl_we   = 1'b1;
               tmpl_addr = 6'(k - 7'd1);
               tmpl_data = mem_rd_data;
            end
            if (k == TW) state_nxt = WIN_START;
         end
         WIN_START: begin
            mem_addr  = img_base + wh_addr;
            wh_en     = 1'b1;
            state_nxt = WIN_WAIT;
         end
         WIN_WAIT: begin
            mem_addr = img_base + wh_addr;
            if (wh_done) state_nxt = WIN_HOLD;
`ifdef SCHED_TIMEOUT_EN
            else if (timeout) begin
               advance   = 1'b1;
               state_nxt = last_pos ? NEXT_SET : WIN_START;
            end
`endif
         end
         WIN_HOLD: begin
            win_valid = 1'b1;
            if (win_ack) begin
               advance   = 1'b1;
               state_nxt = last_pos ? NEXT_SET : WIN_START;
            end
         end
         NEXT_SET: begin
            set_done  = 1'b1;
            state_nxt = (set_index + 16'd1 == NSETS) ? DONE : HDR;
         end
         DONE: begin
            busy      = 1'b0;
            all_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         set_base  <= '0;
         set_index <= '0;
         header    <= '0;
         k         <= '0;
         wh_row    <= '0;
         wh_col    <= '0;
         win_index <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (start) begin
               set_base  <= '0;
               set_index <= '0;
            end
            HDR: k <= '0;
            TMPL: begin
               k <= k + 7'd1;
               if (k == 7'd0) header <= mem_rd_data[7:0];
               if (k == TW) begin
                  wh_row    <= '0;
                  wh_col    <= '0;
                  win_index <= '0;
               end
            end
            NEXT_SET: begin
               set_base  <= set_base + SET_W;
               set_index <= set_index + 16'd1;
            end
            default: ;
         endcase
         if (advance) begin
            win_index <= win_index + 9'd1;
            if (wh_col == LAST_POS) begin
               wh_col <= '0;
               wh_row <= wh_row + STEP_W;
            end else begin
               wh_col <= wh_col + STEP_W;
            end
         end
      end
   end

`ifdef SCHED_TIMEOUT_EN
   // watchdog restarts at every window launch; error stays set until reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
         error  <= 1'b0;
      end else begin
         if (state == WIN_START) wd_cnt <= '0;
         else if (state == WIN_WAIT) wd_cnt <= wd_cnt + 1'b1;
         if (timeout) error <= 1'b1;
      end
   end
`endif

endmodule
